bounce_shifter: RTL and testbench

Parametrised successor to the 18-bit bouncing-light shift register used on the lab board. It holds a WIDTH-bit pattern and advances it on a programmable prescaled tick in one of three modes: bounce between the ends, rotate left or rotate right. It also supports synchronous parallel load and hold, and exposes direction and step/edge pulses so the display driver and sequencing logic can follow the pattern.

---
 rtl/bounce_shifter.sv | 77 +++++++
 tb/tb_bounce_shifter.sv | 115 +++++++++++
 2 files changed

// File: rtl/bounce_shifter.sv
// bounce_shifter: prescaled WIDTH-bit pattern that bounces between the ends or rotates, with load/hold.
module bounce_shifter #(
  parameter int WIDTH = 18,
  parameter int DIV_W = 8,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             R,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             step,
  output logic             edge_hit
);
  logic [DIV_W-1:0] cnt;
  logic             tick, blocked, new_dir, free;
  logic [WIDTH-1:0] q_n;
  logic             dir_n, step_n, edge_n;
  always_comb begin
    tick    = en && (cnt >= div);
    blocked = dir ? q[0] : q[WIDTH-1];
    new_dir = dir ^ blocked;
    free    = new_dir ? !q[0] : !q[WIDTH-1];
    q_n     = q;
    dir_n   = dir;
    step_n  = 1'b0;
    edge_n  = 1'b0;
    case (mode)
      2'b01: begin
        q_n    = {q[WIDTH-2:0], q[WIDTH-1]};
        dir_n  = 1'b0;
        step_n = 1'b1;
      end
      2'b10: begin
        q_n    = {q[0], q[WIDTH-1:1]};
        dir_n  = 1'b1;
        step_n = 1'b1;
      end
      2'b00: if (|q) begin
        // a reversal shifts in the new direction on the same tick unless both ends are occupied
        dir_n  = new_dir;
        edge_n = blocked;
        step_n = free;
        q_n    = !free ? q : new_dir ? {1'b0, q[WIDTH-1:1]} : {q[WIDTH-2:0], 1'b0};
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge R)
    if (R) begin
      q        <= INIT;
      dir      <= 1'b0;
      cnt      <= '0;
      step     <= 1'b0;
      edge_hit <= 1'b0;
    end else if (load) begin
      q        <= din;
      dir      <= 1'b0;
      cnt      <= '0;
      step     <= 1'b0;
      edge_hit <= 1'b0;
    end else begin
      step     <= tick && step_n;
      edge_hit <= tick && edge_n;
      if (en) begin
        cnt <= tick ? '0 : cnt + DIV_W'(1);
        if (tick) begin
          q   <= q_n;
          dir <= dir_n;
        end
      end
    end
endmodule

// File: tb/tb_bounce_shifter.sv
// tb_bounce_shifter: vector table plus scoreboarded sequences for bounce, rotate, prescaler, load and reset.
module tb_bounce_shifter;
  localparam int W  = 18;
  localparam int DW = 8;
  logic          clk = 1'b0, R = 1'b1, en = 1'b0, load = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  din = '0;
  logic [DW-1:0] div = '0;
  logic [W-1:0]  q;
  logic          dir, step, edge_hit;
  int            checks = 0, errors = 0;
  typedef struct {
    logic          en;
    logic [1:0]    mode;
    logic          load;
    logic [W-1:0]  din;
    logic [DW-1:0] div;
    logic [W-1:0]  q;
    logic          dir, step, eh;
  } vec_t;
  typedef struct {
    logic [W+2:0] v;
    string        name;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[$];
  bounce_shifter #(.WIDTH(W), .DIV_W(DW), .INIT(W'(1))) dut (
    .clk(clk), .R(R), .en(en), .mode(mode), .load(load), .din(din), .div(div),
    .q(q), .dir(dir), .step(step), .edge_hit(edge_hit)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got q=%h dir=%b step=%b edge=%b, want q=%h dir=%b step=%b edge=%b",
               name, act[W+2:3], act[2], act[1], act[0], exp[W+2:3], exp[2], exp[1], exp[0]);
    end
  endtask
  task automatic apply(input logic e, input logic [1:0] m, input logic l, input logic [W-1:0] d,
                       input logic [DW-1:0] dv, input logic [W-1:0] eq, input logic ed,
                       input logic es, input logic ee, input string name);
    exp_t x;
    en = e; mode = m; load = l; din = d; div = dv;
    x.v = {eq, ed, es, ee};
    x.name = name;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check(x.name, {q, dir, step, edge_hit}, x.v);
  endtask
  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int k);
    logic [2*W-1:0] w;
    w = {v, v} << k;
    return w[2*W-1:W];
  endfunction
  initial begin
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 2'd0, 1'b0, 18'h0, 8'd0, 18'h00001, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 1'b1, 18'h20000, 8'd0, 18'h20000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 18'h0,     8'd0, 18'h00001, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 18'h0,     8'd0, 18'h20000, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 1'b1, 18'h20001, 8'd0, 18'h20001, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 18'h0,     8'd0, 18'h20001, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 18'h0,     8'd0, 18'h20001, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 18'h0,     8'd0, 18'h20001, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 18'h0,     8'd0, 18'h20001, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 18'h0,     8'd0, 18'h20001, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 18'h0,     8'd0, 18'h20001, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 1'b1, 18'h0,     8'd0, 18'h00000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 18'h0,     8'd0, 18'h00000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 18'h0,     8'd0, 18'h00000, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    check("reset", {q, dir, step, edge_hit}, {18'h00001, 3'b000});
    R = 1'b0;
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].en, tbl[i].mode, tbl[i].load, tbl[i].din, tbl[i].div,
            tbl[i].q, tbl[i].dir, tbl[i].step, tbl[i].eh, $sformatf("tbl%0d", i));
    apply(1, 1, 1, 18'h00005, 0, 18'h00005, 0, 0, 0, "rot_load");
    for (int k = 1; k <= 18; k++)
      apply(1, 1, 0, 0, 0, rotl(18'h00005, k), 0, 1, 0, $sformatf("rotl%0d", k));
    apply(1, 0, 1, 18'h00001, 0, 18'h00001, 0, 0, 0, "sweep_load");
    for (int t = 1; t <= 35; t++) begin
      int pos;
      logic d;
      pos = (t <= 17) ? t : (t <= 34) ? 34 - t : 1;
      d   = (t >= 18 && t <= 34);
      apply(1, 0, 0, 0, 0, W'(1) << pos, d, 1, (t == 18 || t == 35), $sformatf("sweep%0d", t));
    end
    for (int k = 1; k <= 8; k++)
      apply(1, 0, 0, 0, 3, (k < 4) ? 18'h2 : (k < 8) ? 18'h4 : 18'h8, 0, (k % 4 == 0), 0,
            $sformatf("pre%0d", k));
    apply(1, 0, 0, 0, 3, 18'h8,  0, 0, 0, "divdrop_a");
    apply(1, 0, 0, 0, 3, 18'h8,  0, 0, 0, "divdrop_b");
    apply(1, 0, 0, 0, 1, 18'h10, 0, 1, 0, "divdrop_tick");
    apply(1, 0, 1, 18'h00001, 2, 18'h1, 0, 0, 0, "lt_load");
    apply(1, 0, 0, 0, 2, 18'h1, 0, 0, 0, "lt_c1");
    apply(1, 0, 0, 0, 2, 18'h1, 0, 0, 0, "lt_c2");
    apply(1, 0, 1, 18'h00100, 2, 18'h100, 0, 0, 0, "lt_win");
    apply(1, 0, 0, 0, 2, 18'h100, 0, 0, 0, "lt_d1");
    apply(1, 0, 0, 0, 2, 18'h100, 0, 0, 0, "lt_d2");
    apply(1, 0, 0, 0, 2, 18'h200, 0, 1, 0, "lt_shift");
    apply(1, 0, 1, 18'h20000, 0, 18'h20000, 0, 0, 0, "mr_load");
    for (int k = 1; k <= 7; k++)
      apply(1, 0, 0, 0, 0, W'(1) << (17 - k), 1, 1, (k == 1), $sformatf("mr%0d", k));
    #2 R = 1'b1;
    #1 check("mid_reset", {q, dir, step, edge_hit}, {18'h00001, 3'b000});
    #1 R = 1'b0;
    apply(1, 0, 0, 0, 0, 18'h2, 0, 1, 0, "restart1");
    apply(1, 0, 0, 0, 0, 18'h4, 0, 1, 0, "restart2");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
